// File: rtl/four_input_xor_gate_b.sv
// Registered four-input XOR cascade: e=a^b, f=a^b^c, g=a^b^c^d, all with one cycle of latency.
// Every output comes straight from a flop, so no input reaches an output combinationally.
module four_input_xor_gate_b #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] e,
    output logic [WIDTH-1:0] f,
    output logic [WIDTH-1:0] g
);

    logic [WIDTH-1:0] e_d, f_d, g_d;
    logic [WIDTH-1:0] e_q, f_q, g_q;

    // Each stage reuses the previous partial result, so e/f/g share one sampled input set
    always_comb begin
        e_d = a ^ b;
        f_d = e_d ^ c;
        g_d = f_d ^ d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_q <= '0;
            f_q <= '0;
            g_q <= '0;
        end else begin
            e_q <= e_d;
            f_q <= f_d;
            g_q <= g_d;
        end
    end

    assign e = e_q;
    assign f = f_q;
    assign g = g_q;

endmodule

// File: tb/tb_four_input_xor_gate_b.sv
// Directed and random bench for four_input_xor_gate_b at WIDTH=1 and WIDTH=4.
module tb_four_input_xor_gate_b;

    typedef struct {
        logic [3:0] abcd;
        logic [2:0] efg;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic a1, b1, c1, d1;
    logic e1, f1, g1;
    logic [3:0] a4, b4, c4, d4;
    logic [3:0] e4, f4, g4;

    int n_checks = 0;
    int n_pass   = 0;

    vec_t tbl [16];

    always #5 clk = ~clk;

    four_input_xor_gate_b #(.WIDTH(1)) dut1 (
        .clk(clk), .reset(reset),
        .a(a1), .b(b1), .c(c1), .d(d1),
        .e(e1), .f(f1), .g(g1)
    );

    four_input_xor_gate_b #(.WIDTH(4)) dut4 (
        .clk(clk), .reset(reset),
        .a(a4), .b(b4), .c(c4), .d(d4),
        .e(e4), .f(f4), .g(g4)
    );

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic set1(input logic [3:0] v);
        {a1, b1, c1, d1} = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] ra, rb, rc, rd;
        logic [3:0] xa, xb, xc, xd;
        logic       rr, rx;
        logic [2:0] exp1;

        tbl[0]  = '{4'b0000, 3'b000};
        tbl[1]  = '{4'b0001, 3'b001};
        tbl[2]  = '{4'b0010, 3'b011};
        tbl[3]  = '{4'b0011, 3'b010};
        tbl[4]  = '{4'b0100, 3'b111};
        tbl[5]  = '{4'b0101, 3'b110};
        tbl[6]  = '{4'b0110, 3'b100};
        tbl[7]  = '{4'b0111, 3'b101};
        tbl[8]  = '{4'b1000, 3'b111};
        tbl[9]  = '{4'b1001, 3'b110};
        tbl[10] = '{4'b1010, 3'b100};
        tbl[11] = '{4'b1011, 3'b101};
        tbl[12] = '{4'b1100, 3'b000};
        tbl[13] = '{4'b1101, 3'b001};
        tbl[14] = '{4'b1110, 3'b011};
        tbl[15] = '{4'b1111, 3'b010};

        // Reset for two edges with all inputs high
        reset = 1'b1;
        set1(4'b1111);
        a4 = 4'hF; b4 = 4'hF; c4 = 4'hF; d4 = 4'hF;
        for (int i = 0; i < 2; i++) begin
            tick();
            check($sformatf("reset1_%0d", i), {9'd0, e1, f1, g1}, 12'd0);
            check($sformatf("reset4_%0d", i), {e4, f4, g4}, 12'd0);
        end
        reset = 1'b0;

        // Exhaustive WIDTH=1 sweep, d toggles fastest
        for (int i = 0; i < 16; i++) begin
            set1(tbl[i].abcd);
            tick();
            check($sformatf("sweep_%b", tbl[i].abcd), {9'd0, e1, f1, g1}, {9'd0, tbl[i].efg});
        end

        // Latency: d rises between edges; g must wait for the next edge
        set1(4'b0000);
        tick();
        check("lat_base", {9'd0, e1, f1, g1}, 12'd0);
        @(negedge clk);
        d1 = 1'b1;
        #1;
        check("lat_hold", {11'd0, g1}, 12'd0);
        @(posedge clk);
        #1;
        check("lat_load", {11'd0, g1}, 12'd1);

        // Reset mid-stream, then immediate resumption
        set1(4'b1000);
        tick();
        check("mid_pre", {9'd0, e1, f1, g1}, {9'd0, 3'b111});
        reset = 1'b1;
        tick();
        check("mid_reset", {9'd0, e1, f1, g1}, 12'd0);
        reset = 1'b0;
        tick();
        check("mid_resume", {9'd0, e1, f1, g1}, {9'd0, 3'b111});

        // WIDTH=4 vector case
        a4 = 4'hF; b4 = 4'h5; c4 = 4'h3; d4 = 4'h1;
        tick();
        check("w4_vec", {e4, f4, g4}, {4'hA, 4'h9, 4'h8});

        // Random inputs with ~5% reset
        for (int i = 0; i < 1000; i++) begin
            ra = 4'($urandom); rb = 4'($urandom); rc = 4'($urandom); rd = 4'($urandom);
            xa = 4'($urandom); xb = 4'($urandom); xc = 4'($urandom); xd = 4'($urandom);
            rr = ($urandom_range(0, 99) < 5);
            a4 = ra; b4 = rb; c4 = rc; d4 = rd;
            a1 = xa[0]; b1 = xb[0]; c1 = xc[0]; d1 = xd[0];
            reset = rr;
            rx = xa[0] ^ xb[0];
            exp1 = rr ? 3'b000 : {rx, rx ^ xc[0], rx ^ xc[0] ^ xd[0]};
            tick();
            if (rr)
                check($sformatf("rnd4_%0d", i), {e4, f4, g4}, 12'd0);
            else
                check($sformatf("rnd4_%0d", i), {e4, f4, g4},
                      {ra ^ rb, ra ^ rb ^ rc, ra ^ rb ^ rc ^ rd});
            check($sformatf("rnd1_%0d", i), {9'd0, e1, f1, g1}, {9'd0, exp1});
        end
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/four_input_xor_gate_b.md
FOUR_INPUT_XOR_GATE_B -- requirements
Module: four_input_xor_gate_b

Interface
REQ-001 Parameter: WIDTH, default 1, bit width of every data input and output (WIDTH >= 1).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  reset, synchronous and active-high; sampled only on the rising edge of clk.
REQ-004 Port: a  input  WIDTH  first XOR operand.
REQ-005 Port: b  input  WIDTH  second XOR operand.
REQ-006 Port: c  input  WIDTH  third XOR operand.
REQ-007 Port: d  input  WIDTH  fourth XOR operand.
REQ-008 Port: e  output  WIDTH  registered a^b.
REQ-009 Port: f  output  WIDTH  registered a^b^c.
REQ-010 Port: g  output  WIDTH  registered a^b^c^d (four-input XOR result).

Function
REQ-011 Cascade structure: stage 1 = a^b; stage 2 = stage 1 ^ c; stage 3 = stage 2 ^ d; bitwise per bit index.
REQ-012 e, f, g SHALL be driven directly from flip-flops; no combinational path from any input to any output.
REQ-013 Latency exactly 1 cycle: values of a,b,c,d sampled at rising edge N appear on e,f,g after edge N and hold until edge N+1.
REQ-014 All three outputs SHALL update on the same edge from the same sampled input set; no skew between e, f, g.
REQ-015 No enable, no handshake; every non-reset edge loads new results.
REQ-016 Per-bit independence: bit i of each output depends only on bit i of a,b,c,d.
REQ-017 Inputs changing between edges SHALL have no effect on outputs until the next rising edge.
REQ-018 X/Z on inputs is not required to be handled; outputs follow standard XOR propagation.

Reset
REQ-019 When reset=1 at a rising edge, e, f, g SHALL all become 0 on that edge, regardless of a,b,c,d.
REQ-020 Reset has priority over the data load on the same edge.
REQ-021 Reset asserted mid-operation clears outputs at the next edge; no asynchronous effect between edges.
REQ-022 First non-reset edge after reset deassertion loads results from inputs sampled on that edge (1-cycle latency resumes immediately).
REQ-023 Output values before the first reset edge are unspecified; bench SHALL apply reset for at least 2 cycles at start.

Verification
REQ-024 Reset: hold reset=1 for 2 edges with a=b=c=d=1 -> e=f=g=0 after each reset edge.
REQ-025 Exhaustive sweep (WIDTH=1): drive all 16 combos of {a,b,c,d} (d fastest-toggling, a slowest), one per cycle -> one edge later e=a^b, f=a^b^c, g=a^b^c^d; e.g. 1,0,1,1 -> e=1,f=0,g=1; 1,1,1,1 -> e=0,f=1,g=0.
REQ-026 Latency: change inputs from 0,0,0,0 to 0,0,0,1 between edges -> g stays 0 until next rising edge, then g=1.
REQ-027 Reset mid-stream: inputs 1,0,0,0 (outputs e=f=g=1), assert reset for one edge -> e=f=g=0 on that edge; deassert -> next edge e=f=g=1 again.
REQ-028 Vector width (WIDTH=4): a=4'hF, b=4'h5, c=4'h3, d=4'h1 -> e=4'hA, f=4'h9, g=4'h8 one cycle later.
REQ-029 Random: 1000 cycles random inputs and 5% random reset -> outputs match a 1-cycle-delayed reference model every cycle.
